// File: rtl/srp_host_pkg.sv
// Shared types and default sizes for the SRP host-side sequencer.
package srp_host_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_RUN,
      S_DUMP,
      S_FIN
   } host_state_t;

   localparam int DEF_ADDR_W      = 1;
   localparam int DEF_DATA_W      = 1;
   localparam int DEF_DEPTH       = 2;
   localparam int DEF_RES_W       = 2;
   localparam int DEF_INIT_W      = 1;
   localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/srp_dump_buf.sv
// Single-entry output holding register for the array dump stream.
// It is filled from the one-cycle-latency array read and drained by valid/ready.
module srp_dump_buf #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              r_enable,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              space,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   // A new read may be issued when the entry is empty or is leaving this cycle.
   assign space = !out_valid || out_ready;

   // Capture returning read data; otherwise drop the word once it is accepted.
   always_ff @(posedge clk) begin
      if (r_enable) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/srp_host_ctrl.sv
// Host-side sequencer for one SRP kernel: preloads the kernel array, launches
// the kernel, waits for completion (with timeout), then dumps the array.
module srp_host_ctrl
   import srp_host_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int RES_W       = DEF_RES_W,
   parameter int INIT_W      = DEF_INIT_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              r_enable,
   input  logic              start,
   input  logic [INIT_W-1:0] init_arg,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   output logic              du_valid,
   input  logic              du_ready,
   output logic [DATA_W-1:0] du_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [RES_W-1:0]  res,
   output logic              k_r_enable,
   output logic [INIT_W-1:0] k_init,
   input  logic              k_w_enable,
   input  logic [RES_W-1:0]  k_result,
   output logic              k_ctl,
   output logic              k_we,
   output logic [ADDR_W-1:0] k_addr,
   output logic [DATA_W-1:0] k_wdata,
   input  logic [DATA_W-1:0] k_rdata
);

   localparam int AC_W  = ADDR_W + 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   host_state_t       state;
   logic [AC_W-1:0]   a;
   logic [AC_W-1:0]   ack_cnt;
   logic [CNT_W-1:0]  cnt;
   logic [INIT_W-1:0] arg_q;
   logic              ld_ready_q;
   logic              ctl_q;
   logic              rd_pend;
   logic              buf_space;
   logic              ld_hs;
   logic              issue;
   logic              du_hs;

   // Reset releases the array port and the preload stream in the same cycle.
   assign ld_ready = ld_ready_q && !r_enable;
   assign k_ctl    = ctl_q && !r_enable;

   assign ld_hs = (state == S_LOAD) && ld_ready_q && ld_valid && !r_enable;
   assign issue = (state == S_DUMP) && !rd_pend && buf_space &&
                  (a < AC_W'(DEPTH)) && !r_enable;
   assign du_hs = du_valid && du_ready;

   // Drive the control-array port: writes during preload, reads during dump.
   always_comb begin
      k_we    = ld_hs;
      k_addr  = '0;
      k_wdata = '0;
      if (ld_hs) begin
         k_addr  = a[ADDR_W-1:0];
         k_wdata = ld_data;
      end else if (issue) begin
         k_addr = a[ADDR_W-1:0];
      end
   end

   srp_dump_buf #(
      .DATA_W (DATA_W)
   ) u_dump_buf (
      .clk       (clk),
      .r_enable  (r_enable),
      .in_valid  (rd_pend),
      .in_data   (k_rdata),
      .space     (buf_space),
      .out_valid (du_valid),
      .out_ready (du_ready),
      .out_data  (du_data)
   );

   // Sequencer FSM with all host-visible status and kernel controls registered.
   always_ff @(posedge clk) begin
      if (r_enable) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         res        <= '0;
         ld_ready_q <= 1'b0;
         ctl_q      <= 1'b0;
         k_r_enable <= 1'b0;
         k_init     <= '0;
         a          <= '0;
         ack_cnt    <= '0;
         cnt        <= '0;
         arg_q      <= '0;
         rd_pend    <= 1'b0;
      end else begin
         done       <= 1'b0;
         k_r_enable <= 1'b0;
         rd_pend    <= issue;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  arg_q      <= init_arg;
                  a          <= '0;
                  busy       <= 1'b1;
                  ld_ready_q <= 1'b1;
                  ctl_q      <= 1'b1;
                  state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (ld_hs) begin
                  a <= a + AC_W'(1);
                  if (a == AC_W'(DEPTH - 1)) begin
                     ld_ready_q <= 1'b0;
                     ctl_q      <= 1'b0;
                     k_r_enable <= 1'b1;
                     k_init     <= arg_q;
                     state      <= S_KICK;
                  end
               end
            end
            S_KICK: begin
               a       <= '0;
               ack_cnt <= '0;
               cnt     <= '0;
               state   <= S_RUN;
            end
            S_RUN: begin
               if (k_w_enable) begin
                  res   <= k_result;
                  err   <= 1'b0;
                  ctl_q <= 1'b1;
                  state <= S_DUMP;
               end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_FIN;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DUMP: begin
               if (issue) begin
                  a <= a + AC_W'(1);
               end
               if (du_hs) begin
                  ack_cnt <= ack_cnt + AC_W'(1);
                  if (ack_cnt == AC_W'(DEPTH - 1)) begin
                     ctl_q <= 1'b0;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_srp_host_ctrl.sv
// Self-checking bench for srp_host_ctrl with a behavioural kernel stand-in.
module tb_srp_host_ctrl;

   localparam int ADDR_W      = 1;
   localparam int DATA_W      = 1;
   localparam int DEPTH       = 2;
   localparam int RES_W       = 2;
   localparam int INIT_W      = 1;
   localparam int TIMEOUT_CYC = 16;

   logic              clk = 1'b0;
   logic              r_enable = 1'b1;
   logic              start = 1'b0;
   logic [INIT_W-1:0] init_arg = '0;
   logic              ld_valid = 1'b0;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data = '0;
   logic              du_valid;
   logic              du_ready = 1'b0;
   logic [DATA_W-1:0] du_data;
   logic              busy;
   logic              done;
   logic              err;
   logic [RES_W-1:0]  res;
   logic              k_r_enable;
   logic [INIT_W-1:0] k_init;
   logic              k_w_enable = 1'b0;
   logic [RES_W-1:0]  k_result = '0;
   logic              k_ctl;
   logic              k_we;
   logic [ADDR_W-1:0] k_addr;
   logic [DATA_W-1:0] k_wdata;
   logic [DATA_W-1:0] k_rdata = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int kicks = 0;
   int dones = 0;
   logic [RES_W-1:0] res_model = '0;

   logic [DATA_W-1:0] kmem [2**ADDR_W] = '{default: '0};
   logic              kbusy = 1'b0;
   int                klat = 0;
   logic [INIT_W-1:0] karg = '0;
   bit                khang = 1'b0;
   int                klat_cfg = 3;

   srp_host_ctrl #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .RES_W       (RES_W),
      .INIT_W      (INIT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .r_enable   (r_enable),
      .start      (start),
      .init_arg   (init_arg),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .du_valid   (du_valid),
      .du_ready   (du_ready),
      .du_data    (du_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .res        (res),
      .k_r_enable (k_r_enable),
      .k_init     (k_init),
      .k_w_enable (k_w_enable),
      .k_result   (k_result),
      .k_ctl      (k_ctl),
      .k_we       (k_we),
      .k_addr     (k_addr),
      .k_wdata    (k_wdata),
      .k_rdata    (k_rdata)
   );

   always #5 clk = ~clk;

   // Free-running cycle index used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   // Kernel stand-in: host port with registered read, result = {a0,a1},
   // and with init 0 it clears a0; optionally never finishes.
   always @(posedge clk) begin
      if (k_ctl && k_we) kmem[k_addr] <= k_wdata;
      k_rdata <= kmem[k_addr];
      if (k_r_enable) begin
         k_w_enable <= 1'b0;
         kbusy      <= !khang;
         klat       <= klat_cfg;
         karg       <= k_init;
      end else if (kbusy) begin
         if (klat == 0) begin
            kbusy      <= 1'b0;
            k_w_enable <= 1'b1;
            k_result   <= {kmem[0], kmem[1]};
            if (karg == '0) kmem[0] <= '0;
         end else begin
            klat <= klat - 1;
         end
      end
   end

   // Count launch and done pulses over the whole run.
   always @(negedge clk) begin
      if (!r_enable) begin
         if (k_r_enable) kicks <= kicks + 1;
         if (done) dones <= dones + 1;
      end
   end

   task automatic test_reset;
      r_enable = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
      checks++; if (du_valid !== 1'b0)   begin errors++; $display("FAIL reset_du_valid got %b want 0", du_valid); end
      checks++; if (k_r_enable !== 1'b0) begin errors++; $display("FAIL reset_k_r_enable got %b want 0", k_r_enable); end
      checks++; if (k_ctl !== 1'b0)      begin errors++; $display("FAIL reset_k_ctl got %b want 0", k_ctl); end
      checks++; if (k_we !== 1'b0)       begin errors++; $display("FAIL reset_k_we got %b want 0", k_we); end
      checks++; if (res !== '0)          begin errors++; $display("FAIL reset_res got %0h want 0", res); end
      checks++; if (k_addr !== '0)       begin errors++; $display("FAIL reset_k_addr got %0h want 0", k_addr); end
      checks++; if (k_wdata !== '0)      begin errors++; $display("FAIL reset_k_wdata got %0h want 0", k_wdata); end
      checks++; if (k_init !== '0)       begin errors++; $display("FAIL reset_k_init got %0h want 0", k_init); end
      r_enable = 1'b0;
      res_model = '0;
      @(negedge clk);
   endtask

   // One full accepted start: preload, launch, wait, dump; checked against
   // expectations derived from the preload words and argument.
   task automatic run_seq(input logic [DEPTH*DATA_W-1:0] words, input logic [INIT_W-1:0] arg,
                          input int ld_mode, input int rdy_mode, input bit hang,
                          input bit poke_start, input string tag);
      logic [DATA_W-1:0] exp_dump [$];
      logic [DATA_W-1:0] got_dump [$];
      logic [RES_W-1:0]  exp_res;
      logic [DATA_W-1:0] pend_data;
      logic              pat [4];
      int start_cyc, kick_cyc, wen_cyc, fv_cyc, hs_cyc, done_cyc, ld_idx, kicks0, dones0;
      bit in_run, pend, got_done, poked;

      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      if (hang) begin
         exp_res = res_model;
      end else begin
         exp_res = RES_W'(words[0] * 2 + words[1]);
         exp_dump.push_back((arg == '0) ? 1'b0 : words[0]);
         exp_dump.push_back(words[1]);
      end
      khang    = hang;
      klat_cfg = poke_start ? 6 : int'($urandom_range(0, 8));
      kicks0   = kicks;
      dones0   = dones;
      kick_cyc = -1; wen_cyc = -1; fv_cyc = -1; hs_cyc = -1; done_cyc = -1;
      ld_idx = 0; in_run = 0; pend = 0; got_done = 0; poked = 0;
      pend_data = '0;

      start = 1'b1; init_arg = arg; start_cyc = cyc;
      ld_valid = 1'b0; du_ready = 1'b0;
      for (int n = 0; n < 300 && !got_done; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (k_r_enable) begin kick_cyc = cyc; in_run = 1; end
         if (in_run) begin
            checks++;
            if (k_ctl !== 1'b0) begin errors++; $display("FAIL %s k_ctl_run got %b want 0 at cycle %0d", tag, k_ctl, cyc); end
            if (k_w_enable && cyc > kick_cyc) begin wen_cyc = cyc; in_run = 0; end
         end
         if (pend) begin
            checks++;
            if (du_valid !== 1'b1 || du_data !== pend_data) begin
               errors++; $display("FAIL %s dump_hold got valid=%b data=%0h want valid=1 data=%0h", tag, du_valid, du_data, pend_data);
            end
         end
         if (du_valid === 1'b1 && fv_cyc < 0) fv_cyc = cyc;
         if (done === 1'b1) begin
            got_done = 1; done_cyc = cyc;
         end else begin
            ld_valid = (ld_idx < DEPTH) && (ld_mode == 0 || $urandom_range(0, 1) == 1);
            ld_data  = (ld_idx < DEPTH) ? words[ld_idx] : '0;
            if (rdy_mode == 0)      du_ready = 1'b1;
            else if (rdy_mode == 1) du_ready = ($urandom_range(0, 1) == 1);
            else                    du_ready = (fv_cyc < 0) ? 1'b0 : pat[(cyc - fv_cyc) % 4];
            if (poke_start && !poked && kick_cyc >= 0 && cyc == kick_cyc + 2) begin start = 1'b1; poked = 1; end
            if (ld_ready && ld_valid) ld_idx++;
            if (du_valid && du_ready) begin
               got_dump.push_back(du_data); hs_cyc = cyc; pend = 0;
            end else begin
               pend = du_valid; pend_data = du_data;
            end
         end
      end
      ld_valid = 1'b0; du_ready = 1'b0; start = 1'b0;

      checks++;
      if (!got_done) begin
         errors++; $display("FAIL %s done_timeout got no done want done within 300 cycles", tag);
      end else begin
         checks++; if (err !== hang) begin errors++; $display("FAIL %s err got %b want %b", tag, err, hang); end
         checks++; if (res !== exp_res) begin errors++; $display("FAIL %s res got %0h want %0h", tag, res, exp_res); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_at_done got %b want 1", tag, busy); end
         checks++;
         if (got_dump.size() != exp_dump.size()) begin
            errors++; $display("FAIL %s dump_count got %0d want %0d", tag, got_dump.size(), exp_dump.size());
         end else begin
            foreach (exp_dump[i]) begin
               checks++;
               if (got_dump[i] !== exp_dump[i]) begin
                  errors++; $display("FAIL %s dump_word%0d got %0h want %0h", tag, i, got_dump[i], exp_dump[i]);
               end
            end
         end
         if (hang) begin
            checks++;
            if (done_cyc != kick_cyc + TIMEOUT_CYC + 1) begin
               errors++; $display("FAIL %s timeout_latency got %0d want %0d", tag, done_cyc - kick_cyc, TIMEOUT_CYC + 1);
            end
         end else begin
            checks++;
            if (done_cyc != hs_cyc + 1) begin
               errors++; $display("FAIL %s done_after_last got %0d want 1", tag, done_cyc - hs_cyc);
            end
            checks++;
            if (wen_cyc < 0 || fv_cyc != wen_cyc + 3) begin
               errors++; $display("FAIL %s first_dump_latency got fv=%0d wen=%0d want fv=wen+3", tag, fv_cyc, wen_cyc);
            end
         end
         if (ld_mode == 0) begin
            checks++;
            if (kick_cyc != start_cyc + DEPTH + 1) begin
               errors++; $display("FAIL %s kick_latency got %0d want %0d", tag, kick_cyc - start_cyc, DEPTH + 1);
            end
         end
      end
      res_model = exp_res;

      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after_done got %b want 0", tag, busy); end
      checks++; if (kicks - kicks0 != 1) begin errors++; $display("FAIL %s kick_pulses got %0d want 1", tag, kicks - kicks0); end
      checks++; if (dones - dones0 != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", tag, dones - dones0); end
   endtask

   task automatic test_directed;
      run_seq(2'b11, 1'b0, 0, 0, 1'b0, 1'b0, "preload11_init0");
      run_seq(2'b01, 1'b1, 0, 0, 1'b0, 1'b0, "preload10_init1");
   endtask

   task automatic test_backpressure;
      run_seq(2'($urandom_range(0, 3)), 1'b1, 0, 2, 1'b0, 1'b0, "backpressure_a");
      run_seq(2'($urandom_range(0, 3)), 1'b0, 0, 2, 1'b0, 1'b0, "backpressure_b");
   endtask

   task automatic test_timeout;
      run_seq(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, 1'b1, 1'b0, "timeout");
   endtask

   task automatic test_reset_mid_load;
      start = 1'b1; init_arg = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL midload_ld_ready got %b want 1", ld_ready); end
      ld_valid = 1'b1; ld_data = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0; r_enable = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midload_busy got %b want 0", busy); end
      checks++; if (k_ctl !== 1'b0) begin errors++; $display("FAIL midload_k_ctl got %b want 0", k_ctl); end
      r_enable = 1'b0;
      res_model = '0;
      @(negedge clk);
      run_seq(2'b10, 1'b1, 0, 0, 1'b0, 1'b0, "reload_after_reset");
   endtask

   task automatic test_start_during_run;
      run_seq(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, 1'b0, 1'b1, "start_in_run");
   endtask

   task automatic test_random;
      for (int i = 0; i < 20; i++) begin
         run_seq(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), 1'b0, 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_timeout();
      test_directed();
      test_reset_mid_load();
      test_start_during_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
